// File: rtl/pipelined_mac_pkg.sv
// Shared limits, beat tag type and width helper for the pipelined unsigned MAC.
package pipelined_mac_pkg;

    localparam int unsigned MAX_WIDTH = 27;
    localparam int unsigned MAX_ACC   = 48;

    typedef struct packed {
        logic first;
        logic last;
        logic valid;
    } beat_tag_t;

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Product pipeline: STAGES registers carrying a*b and the beat tag, advancing only on en.
module mac_mult_pipe
    import pipelined_mac_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    input  beat_tag_t                        tag_in,
    output logic [prod_width(WIDTH)-1:0]     prod_out,
    output beat_tag_t                        tag_out
);

    localparam int unsigned PW = prod_width(WIDTH);

    logic [PW-1:0] prod_q [STAGES];
    logic [PW-1:0] prod_d [STAGES];
    beat_tag_t     tag_q  [STAGES];
    beat_tag_t     tag_d  [STAGES];

    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            prod_d[i] = prod_q[i];
            tag_d[i]  = tag_q[i];
        end
        if (en) begin
            prod_d[0] = PW'(a) * PW'(b);
            tag_d[0]  = tag_in;
            for (int unsigned i = 1; i < STAGES; i++) begin
                prod_d[i] = prod_q[i-1];
                tag_d[i]  = tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                prod_q[i] <= prod_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    assign prod_out = prod_q[STAGES-1];
    assign tag_out  = tag_q[STAGES-1];

endmodule

// File: rtl/pipelined_mac.sv
// Pipelined unsigned multiply-accumulate with valid/ready flow control.
// Define PIPELINED_MAC_SAT_EN to saturate the accumulator instead of wrapping.
module pipelined_mac
    import pipelined_mac_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 48,
    parameter int unsigned STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] p,
    output logic                 overflow
);

    localparam int unsigned PW = prod_width(WIDTH);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("pipelined_mac: WIDTH out of range");
    end
    if (ACC_WIDTH < PW || ACC_WIDTH > MAX_ACC) begin : g_bad_acc
        $error("pipelined_mac: ACC_WIDTH out of range");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("pipelined_mac: STAGES out of range");
    end

    logic                 en;
    beat_tag_t            tag_in;
    beat_tag_t            tag_s;
    logic [PW-1:0]        prod_s;
    logic [ACC_WIDTH:0]   sum;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_acc_q, ovf_acc_d;
    logic [ACC_WIDTH-1:0] p_q, p_d;
    logic                 overflow_q, overflow_d;
    logic                 out_valid_q, out_valid_d;

    // One enable freezes every stage together, so a stalled result never gets overtaken.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    assign tag_in = '{first: in_first, last: in_last, valid: in_valid};

    mac_mult_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a        (a),
        .b        (b),
        .tag_in   (tag_in),
        .prod_out (prod_s),
        .tag_out  (tag_s)
    );

    always_comb begin
        sum = {1'b0, (tag_s.first ? '0 : acc_q)}
            + {{(ACC_WIDTH + 1 - PW){1'b0}}, prod_s};

        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        p_d         = p_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;

        if (en) begin
            out_valid_d = 1'b0;
            if (tag_s.valid) begin
`ifdef PIPELINED_MAC_SAT_EN
                acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
                acc_d = sum[ACC_WIDTH-1:0];
`endif
                ovf_acc_d = (tag_s.first ? 1'b0 : ovf_acc_q) | sum[ACC_WIDTH];
                if (tag_s.last) begin
                    p_d         = acc_d;
                    overflow_d  = ovf_acc_d;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            p_q         <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            p_q         <= p_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule
